sw_input_conditioner: RTL
=========================

Name: sw_input_conditioner

Overview:
- Conditions the 8 board slide switches before they reach the I/O input ports of the single-cycle computer.
- Synchronises and debounces each switch, then presents two zero-extended 4-bit operands as 32-bit in_port words.
- Adds a sticky new-data flag and an event counter so software polling the input ports can detect changes.
- Sits between the raw sw pins and the data-memory/LED I/O input side.

Parameters:
WIDTH, 8, number of switch bits; fixed split at WIDTH/2 (must be even, >=2)
DEBOUNCE_CYCLES, 16, consecutive clock cycles a synchronised bit must differ from its stable value before the stable value updates (>=2; use 4 in simulation)

Ports:
clock  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
sw  input  WIDTH  raw asynchronous switch inputs
rd_ack  input  1  one-cycle pulse from the I/O read path; clears new_data
in_port0  output  32  {zero-extend, sw_stable[WIDTH/2-1:0]}
in_port1  output  32  {zero-extend, sw_stable[WIDTH-1:WIDTH/2]}
sw_stable  output  WIDTH  debounced switch vector
change_pulse  output  1  high for exactly one cycle when sw_stable changes
new_data  output  1  sticky flag: sw_stable changed since last rd_ack
event_count  output  8  count of sw_stable change events, wraps 255->0

Behaviour:
- Reset: synchronous, sampled on the rising edge while resetn=0. Clears sync1, sync2, all per-bit counters, sw_stable, change_pulse, new_data and event_count to 0; in_port0 and in_port1 read 0. Reset mid-debounce discards partial counts.
- Synchroniser: two flops per bit, sync1<=sw and sync2<=sync1. No logic between the stages.
- Per-bit debounce (independent counter cnt[i], width clog2(DEBOUNCE_CYCLES)):
  - If sync2[i]==sw_stable[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: sw_stable[i]<=sync2[i] and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches sw_stable.
- Latency: a clean sw edge sampled by sync1 on edge k becomes visible on sw_stable after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges including edge k.
- in_port0 and in_port1 are wires from the sw_stable register. No extra latency; upper bits are always 0.
- change_pulse is registered and equals OR over i of the bits updating on that edge. It is high in the same cycle the new sw_stable is visible and low the next cycle unless another bit updates.
- Several bits updating on the same edge produce a single change_pulse and a single event_count increment.
- new_data:
  - Set on any edge where sw_stable updates.
  - Cleared on an edge where rd_ack=1 and no update occurs.
  - Simultaneous update and rd_ack: set wins, new_data stays 1.
  - rd_ack while new_data=0: no effect.
- event_count increments by 1 per change event, modulo 256.
- Power-up case: switches already set at reset release produce one change event after DEBOUNCE_CYCLES+2 cycles, because sw_stable resets to 0. Software must tolerate this event.
- No combinational path from sw or rd_ack to any output.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset: hold resetn=0 for 3 cycles with sw=8'hA5, then release. All outputs stay 0 until 6 edges after release. Then sw_stable=8'hA5, in_port0=32'h5, in_port1=32'hA, change_pulse for 1 cycle, new_data=1, event_count=1.
2. Clean change: from stable 8'h00, set sw=8'h0F at edge k. sw_stable=8'h0F after edge k+5, not before. in_port0=32'hF, in_port1=32'h0, event_count increments by 1.
3. Bounce rejection: toggle sw[3] with high phases of 1, 2 and 3 cycles separated by 1-cycle lows. sw_stable, change_pulse and event_count are unchanged.
4. Simultaneous change: set sw 8'h00->8'hFF in one cycle. All bits update on the same edge. change_pulse is high for exactly 1 cycle, event_count increments by exactly 1, in_port1=32'hF.
5. new_data handshake: after a change, pulse rd_ack, and new_data clears the next edge. Then assert rd_ack on the same edge that sw_stable updates: new_data remains 1.
6. Wrap and reset mid-operation: drive 256 clean changes and check event_count returns to 0. Start a change, assert resetn=0 at count 2, and check all outputs are 0 and the counter restarts the full 4 cycles after release.

Source files
------------

// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: conditions the board slide switches before they reach
// the I/O input ports. Each switch bit is synchronised with two flops and
// debounced by its own counter. The stable vector is split into two
// zero-extended 32-bit operand words. A change pulse, a sticky new-data flag
// and an event counter let polling software see when the switches moved.
module sw_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw,
  input  logic             rd_ack,
  output logic [31:0]      in_port0,
  output logic [31:0]      in_port1,
  output logic [WIDTH-1:0] sw_stable,
  output logic             change_pulse,
  output logic             new_data,
  output logic [7:0]       event_count
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] upd;
  logic             any_upd;

  // Two-flop synchroniser per bit, nothing between the stages
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // A bit updates once it has disagreed with its stable value for the full window
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (sync2[i] != sw_stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign any_upd = |upd;

  // Per-bit debounce counters; any agreement restarts the count
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sw_stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          sw_stable[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Change reporting: several bits on one edge count as a single event;
  // an update on the same edge as rd_ack keeps new_data set
  always_ff @(posedge clock) begin
    if (!resetn) begin
      change_pulse <= 1'b0;
      new_data     <= 1'b0;
      event_count  <= 8'd0;
    end else begin
      change_pulse <= any_upd;
      if (any_upd) begin
        new_data    <= 1'b1;
        event_count <= event_count + 8'd1;
      end else if (rd_ack) begin
        new_data <= 1'b0;
      end
    end
  end

  assign in_port0 = {{(32-HALF){1'b0}}, sw_stable[HALF-1:0]};
  assign in_port1 = {{(32-HALF){1'b0}}, sw_stable[WIDTH-1:HALF]};

endmodule
